// File: rtl/adc_sample_sequencer.sv
// Periodic ADC burst sequencer: one channel per burst, round-robin rotation,
// burst readings averaged into a one-cycle-valid sample, with hung-transaction
// timeout and period-overrun detection.
module adc_sample_sequencer #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       clr_err,
  input  logic       adc_busy,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic       adc_start,
  output logic [1:0] adc_chan,
  output logic [7:0] sample_out,
  output logic [1:0] sample_chan,
  output logic       sample_valid,
  output logic       overrun,
  output logic       timeout_err,
  output logic [2:0] STATE
);

  localparam int unsigned PW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned AW  = 8 + AVG_LOG2;
  localparam int unsigned CW  = AVG_LOG2 + 1;
  localparam int unsigned NRD = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START     = 3'd2,
    S_CONVERT   = 3'd3,
    S_EMIT      = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   per_cnt;
  logic            tick;
  logic [AW-1:0]   acc, acc_next, sum;
  logic [CW-1:0]   rd_cnt, rd_next;
  logic [TW-1:0]   to_cnt, to_next;
  logic [1:0]      chan, chan_next, chan_adv;
  logic            emit_load;
  logic            timeout_set;
  logic            overrun_set;

  assign tick        = EN && (per_cnt == PW'(SAMPLE_PERIOD - 1));
  assign sum         = acc + AW'(adc_data);
  assign chan_adv    = (chan == 2'(NUM_CH - 1)) ? 2'd0 : chan + 2'd1;
  assign overrun_set = tick && (state != S_WAIT_TICK);
  assign adc_chan    = chan;
  assign STATE       = state;

  // Sample-period counter; parked at zero while sampling is disabled
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      per_cnt <= '0;
    end else if (per_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath updates and the start strobe
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    rd_next     = rd_cnt;
    to_next     = to_cnt;
    chan_next   = chan;
    emit_load   = 1'b0;
    timeout_set = 1'b0;
    adc_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN) state_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!EN) begin
          state_next = S_IDLE;
        end else if (tick) begin
          state_next = S_START;
          acc_next   = '0;
          rd_next    = '0;
        end
      end
      S_START: begin
        if (!adc_busy) begin
          adc_start  = 1'b1;
          to_next    = '0;
          state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // A done arriving on the timeout cycle still counts as a reading
        if (adc_done) begin
          acc_next = sum;
          rd_next  = rd_cnt + 1'b1;
          if (rd_cnt == CW'(NRD - 1)) begin
            state_next = S_EMIT;
            emit_load  = 1'b1;
          end else begin
            state_next = S_START;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          chan_next   = chan_adv;
          state_next  = S_WAIT_TICK;
        end else begin
          to_next = to_cnt + 1'b1;
        end
      end
      S_EMIT: begin
        chan_next  = chan_adv;
        state_next = EN ? S_WAIT_TICK : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers, sample outputs and sticky error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc          <= '0;
      rd_cnt       <= '0;
      to_cnt       <= '0;
      chan         <= '0;
      sample_out   <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      acc          <= acc_next;
      rd_cnt       <= rd_next;
      to_cnt       <= to_next;
      chan         <= chan_next;
      sample_valid <= emit_load;
      if (emit_load) begin
        sample_out  <= 8'(sum >> AVG_LOG2);
        sample_chan <= chan;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: an ADC model answers each start,
// a burst-level reference predicts averaged samples and timeouts, and a
// separate monitor compares every sample_valid / timeout_err rise.
module tb_adc_sample_sequencer;

  localparam int P    = 20;
  localparam int AVG  = 2;
  localparam int TO   = 50;
  localparam int NCH  = 4;

  logic       CLK = 1'b0;
  logic       RST, EN, clr_err, adc_busy;
  logic       adc_done, adc_start;
  logic [7:0] adc_data, sample_out;
  logic [1:0] adc_chan, sample_chan;
  logic       sample_valid, overrun, timeout_err;
  logic [2:0] STATE;

  logic       model_done = 1'b0;
  logic       stray_done = 1'b0;
  logic [7:0] model_data = 8'd0;
  logic [7:0] stray_data = 8'd0;

  assign adc_done = model_done | stray_done;
  assign adc_data = stray_done ? stray_data : model_data;

  adc_sample_sequencer #(
    .NUM_CH(NCH), .SAMPLE_PERIOD(P), .AVG_LOG2(AVG), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .clr_err(clr_err),
    .adc_busy(adc_busy), .adc_done(adc_done), .adc_data(adc_data),
    .adc_start(adc_start), .adc_chan(adc_chan),
    .sample_out(sample_out), .sample_chan(sample_chan),
    .sample_valid(sample_valid), .overrun(overrun),
    .timeout_err(timeout_err), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int data;
    int chan;
    int cyc;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_samples = 0;
  exp_t exp_q[$];
  int   to_q[$];
  int   data_q[$];

  // Reference model state (burst-level view of the sequencer)
  int lat = 3;          // keeps a 4-reading burst inside the 20-cycle period
  bit hang_en = 1'b0;
  int hang_ch = 2;
  bit max_mode = 1'b0;
  int exp_chan = 0;
  int burst_sum = 0;
  int burst_n = 0;
  bit pending = 1'b0;
  int due = 0;
  int m_d = 0;
  bit prev_to = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (data_q.size() > 0) return data_q.pop_front();
    if (max_mode) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  // ADC model + expected-result producer; samples just before the active edge
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      model_done = 1'b0;
      if (RST) begin
        pending   = 1'b0;
        burst_sum = 0;
        burst_n   = 0;
        exp_chan  = 0;
      end else begin
        if (pending && cyc == due) begin
          m_d        = pick();
          model_data = 8'(m_d);
          model_done = 1'b1;
          pending    = 1'b0;
          burst_sum += m_d;
          burst_n++;
          if (burst_n == (1 << AVG)) begin
            exp_q.push_back('{burst_sum / (1 << AVG), exp_chan, cyc + 1});
            exp_chan  = (exp_chan + 1) % NCH;
            burst_sum = 0;
            burst_n   = 0;
          end
        end
        if (adc_start === 1'b1) begin
          chk("start_chan", 32'(adc_chan), 32'(exp_chan));
          chk("start_while_busy", 32'(adc_busy), 32'd0);
          if (hang_en && exp_chan == hang_ch) begin
            hang_en = 1'b0;
            to_q.push_back(cyc + TO + 1);
            exp_chan  = (exp_chan + 1) % NCH;
            burst_sum = 0;
            burst_n   = 0;
          end else begin
            pending = 1'b1;
            due     = cyc + lat;
          end
        end
      end
    end
  end

  // Monitor: compare every presented sample and every timeout_err rise
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sample_valid === 1'b1) begin
        n_samples++;
        if (exp_q.size() == 0) begin
          chk("sample_valid_unexpected", 32'(sample_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sample_out", 32'(sample_out), 32'(e.data));
          chk("sample_chan", 32'(sample_chan), 32'(e.chan));
          chk("sample_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (timeout_err === 1'b1 && !prev_to) begin
        if (to_q.size() == 0) chk("timeout_unexpected", 32'(timeout_err), 32'd0);
        else                  chk("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
      end
      prev_to = (timeout_err === 1'b1);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_state(input int s, input string nm);
    int b = 0;
    while (STATE !== 3'(s) && b < 200) begin
      step();
      b++;
    end
    chk(nm, 32'(STATE), 32'(s));
  endtask

  task automatic wait_samples(input int k, input string nm);
    int tgt = n_samples + k;
    int b = 0;
    while (n_samples < tgt && b < 300 * k) begin
      step();
      b++;
    end
    chk(nm, 32'(n_samples), 32'(tgt));
  endtask

  task automatic clear_errors();
    wait_state(1, "clr_wait");
    @(negedge CLK) clr_err = 1'b1;
    @(negedge CLK) clr_err = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus sequence
  initial begin
    int c0;
    int b;
    RST = 1'b1; EN = 1'b1; clr_err = 1'b0; adc_busy = 1'b0;
    data_q = '{10, 11, 12, 13};

    // Reset with EN high
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_adc_chan", 32'(adc_chan), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_flags", 32'({overrun, timeout_err}), 32'd0);
    @(negedge CLK) RST = 1'b0;
    step();
    c0 = cyc;
    chk("release_state", 32'(STATE), 32'd1);
    b = 0;
    while (adc_start !== 1'b1 && b < 100) begin
      step();
      b++;
    end
    // Counter leaves 0 on the release edge, so the tick cycle is c0+P-2
    chk("first_start_latency", 32'(cyc - c0), 32'(P - 1));

    // Basic burst 10,11,12,13 -> 11 on channel 0
    wait_samples(1, "basic_burst");
    chk("basic_avg", 32'(sample_out), 32'd11);
    chk("basic_chan", 32'(sample_chan), 32'd0);

    wait_samples(3, "random_bursts");

    // Full-scale readings across a channel wrap
    max_mode = 1'b1;
    wait_samples(5, "max_bursts");
    max_mode = 1'b0;
    chk("max_avg", 32'(sample_out), 32'd255);

    // adc_busy held across the tick delays the start
    wait_state(1, "busy_wait_tick");
    @(negedge CLK) adc_busy = 1'b1;
    wait_state(2, "busy_in_start");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("busy_no_start", 32'(adc_start), 32'd0);
    end
    @(negedge CLK) adc_busy = 1'b0;
    #1;
    chk("start_on_busy_drop", 32'(adc_start), 32'd1);
    wait_samples(1, "busy_burst");

    // Stray done in WAIT_TICK must not disturb the next burst
    wait_state(1, "stray_wait_tick");
    @(negedge CLK) begin stray_done = 1'b1; stray_data = 8'd200; end
    @(negedge CLK) stray_done = 1'b0;
    wait_samples(1, "after_stray");
    clear_errors();
    chk("flags_cleared", 32'({overrun, timeout_err}), 32'd0);

    // Channel 2 never answers
    hang_en = 1'b1;
    b = 0;
    while (timeout_err !== 1'b1 && b < 400) begin
      step();
      b++;
    end
    chk("timeout_seen", 32'(timeout_err), 32'd1);
    chk("timeout_to_wait", 32'(STATE), 32'd1);
    chk("timeout_overrun", 32'(overrun), 32'd1);
    clear_errors();
    chk("timeout_cleared", 32'(timeout_err), 32'd0);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    wait_samples(1, "after_timeout");
    chk("after_timeout_chan", 32'(sample_chan), 32'd3);

    // Slow ADC stretches the burst past the period
    chk("overrun_before", 32'(overrun), 32'd0);
    wait_state(1, "slow_wait_tick");
    lat = 6;
    wait_samples(1, "slow_burst");
    lat = 3;
    chk("overrun_set", 32'(overrun), 32'd1);
    clear_errors();
    chk("overrun_clr", 32'(overrun), 32'd0);

    // EN dropped mid-burst: burst completes, then IDLE
    wait_state(3, "en_wait_convert");
    @(negedge CLK) EN = 1'b0;
    wait_samples(1, "en_low_burst");
    step();
    chk("en_low_idle", 32'(STATE), 32'd0);
    @(negedge CLK) EN = 1'b1;

    // Reset in CONVERT abandons the burst
    wait_state(3, "rst_wait_convert");
    @(negedge CLK) RST = 1'b1;
    step();
    chk("midrst_state", 32'(STATE), 32'd0);
    chk("midrst_adc_start", 32'(adc_start), 32'd0);
    chk("midrst_chan", 32'(adc_chan), 32'd0);
    chk("midrst_sample_valid", 32'(sample_valid), 32'd0);
    @(negedge CLK) RST = 1'b0;
    wait_samples(2, "after_midrst");

    repeat (10) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("to_q_drained", 32'(to_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
